fastcmd_frame_aligner: RTL and testbench

Recovers the 40 MHz frame boundary from the 320 Mb/s serial fast-command stream. It hunts for the IDLE codeword, locks onto its phase, and then emits one `clk_sync_tx` pulse per 8-bit frame. That pulse drives the `en` input of the 40 MHz clock decoder directly downstream. Each aligned 8-bit frame is also presented to the command decoder, with lock status and loss-of-lock indication.

---
 rtl/fastcmd_frame_aligner.sv | 159 +++++++++++++++
 tb/tb_fastcmd_frame_aligner.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fastcmd_frame_aligner.sv
// Purpose : recover the 8-bit frame boundary of the serial fast-command stream by locking onto IDLE_WORD.
// Latency : clk_sync_tx / cmd_word / cmd_valid are registered, visible one cycle after the frame's last bit.
// Backpr. : none; the stream is free-running and every output is a registered pulse or level.
//
// Ports:
//   clk         - bit-rate clock; din is sampled on its rising edge
//   n_reset     - asynchronous active-low reset
//   din         - serial command bit, MSB of each frame first
//   clk_sync_tx - one-cycle pulse per aligned frame while locked (drives downstream decoder enable)
//   cmd_word    - last aligned frame
//   cmd_valid   - one-cycle pulse when cmd_word is a non-IDLE frame taken while locked
//   locked      - high while the frame phase is locked
//   lock_lost   - one-cycle pulse when lock is dropped after too many non-IDLE frames
module fastcmd_frame_aligner #(
    parameter logic [7:0] IDLE_WORD    = 8'hAC,
    parameter int         LOCK_COUNT   = 4,
    parameter int         IDLE_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       din,
    output logic       clk_sync_tx,
    output logic [7:0] cmd_word,
    output logic       cmd_valid,
    output logic       locked,
    output logic       lock_lost
);

    localparam int TW = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      sr_q, sr_d;
    logic [2:0]      phase_q, phase_d;
    logic [3:0]      match_q, match_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            sync_q, sync_d;
    logic [7:0]      word_q, word_d;
    logic            valid_q, valid_d;
    logic            locked_q, locked_d;
    logic            lost_q, lost_d;

    logic            idle_hit;
    logic            boundary;
    logic [3:0]      match_inc;
    logic [TW-1:0]   tmo_inc;

    always_comb begin
        // Every pattern decision looks at the window including this cycle's bit.
        sr_d      = {sr_q[6:0], din};
        idle_hit  = (sr_d == IDLE_WORD);
        boundary  = (phase_q == 3'd7);
        match_inc = match_q + 4'd1;
        // Saturating increment: the count must never wrap back below the timeout.
        tmo_inc   = (tmo_q == {TW{1'b1}}) ? tmo_q : tmo_q + {{(TW-1){1'b0}}, 1'b1};

        state_d  = state_q;
        phase_d  = phase_q + 3'd1;
        match_d  = match_q;
        tmo_d    = tmo_q;
        sync_d   = 1'b0;
        valid_d  = 1'b0;
        lost_d   = 1'b0;
        word_d   = word_q;
        locked_d = locked_q;

        case (state_q)
            ST_HUNT: begin
                if (idle_hit) begin
                    // Counter restarts so that it reads 7 exactly when the next frame completes.
                    phase_d = 3'd0;
                    match_d = 4'd1;
                    state_d = ST_VERIFY;
                end
            end

            ST_VERIFY: begin
                if (boundary) begin
                    if (idle_hit) begin
                        match_d = match_inc;
                        if (match_inc == 4'(LOCK_COUNT)) begin
                            // The locking frame already produces the first sync pulse.
                            state_d  = ST_LOCKED;
                            tmo_d    = '0;
                            sync_d   = 1'b1;
                            word_d   = sr_d;
                            locked_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_HUNT;
                        match_d = 4'd0;
                    end
                end
            end

            ST_LOCKED: begin
                if (boundary) begin
                    sync_d = 1'b1;
                    word_d = sr_d;
                    if (idle_hit) begin
                        tmo_d = '0;
                    end else begin
                        valid_d = 1'b1;
                        tmo_d   = tmo_inc;
                        // The final frame still gets its sync/valid pulses.
                        if (tmo_inc == TW'(IDLE_TIMEOUT)) begin
                            state_d  = ST_HUNT;
                            lost_d   = 1'b1;
                            locked_d = 1'b0;
                        end
                    end
                end
            end

            default: begin
                state_d  = ST_HUNT;
                locked_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q  <= ST_HUNT;
            sr_q     <= 8'h00;
            phase_q  <= 3'd0;
            match_q  <= 4'd0;
            tmo_q    <= '0;
            sync_q   <= 1'b0;
            word_q   <= 8'h00;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            phase_q  <= phase_d;
            match_q  <= match_d;
            tmo_q    <= tmo_d;
            sync_q   <= sync_d;
            word_q   <= word_d;
            valid_q  <= valid_d;
            locked_q <= locked_d;
            lost_q   <= lost_d;
        end
    end

    assign clk_sync_tx = sync_q;
    assign cmd_word    = word_q;
    assign cmd_valid   = valid_q;
    assign locked      = locked_q;
    assign lock_lost   = lost_q;

endmodule

// File: tb/tb_fastcmd_frame_aligner.sv
// Purpose : randomized self-checking bench for fastcmd_frame_aligner against a time-based reference model.
// Latency : each step drives one bit at negedge and compares outputs 1 ns after the following posedge.
// Backpr. : not applicable; the stream is free-running.
module tb_fastcmd_frame_aligner;

    localparam logic [7:0] IDLE         = 8'hAC;
    localparam int         LOCK_COUNT   = 4;
    localparam int         IDLE_TIMEOUT = 64;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       din = 1'b0;
    logic       clk_sync_tx;
    logic [7:0] cmd_word;
    logic       cmd_valid;
    logic       locked;
    logic       lock_lost;

    always #5 clk = ~clk;

    fastcmd_frame_aligner #(
        .IDLE_WORD    (IDLE),
        .LOCK_COUNT   (LOCK_COUNT),
        .IDLE_TIMEOUT (IDLE_TIMEOUT)
    ) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .din         (din),
        .clk_sync_tx (clk_sync_tx),
        .cmd_word    (cmd_word),
        .cmd_valid   (cmd_valid),
        .locked      (locked),
        .lock_lost   (lock_lost)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: tracks absolute bit time since reset and the time of the
    // IDLE that set the phase; frame boundaries are every 8th bit after it.
    bit         m_bits[$];
    int         m_mode;          // 0 = hunting, 1 = verifying, 2 = locked
    int         m_t;
    int         m_anchor;
    int         m_nidle;
    int         m_nbad;
    logic       m_sync, m_valid, m_lost, m_locked;
    logic [7:0] m_word;

    // DUT-side observation counters for section-level checks.
    int cnt_sync, cnt_valid, cnt_lost, cnt_rise, rise_t, last_sync;
    logic prev_locked;

    task automatic model_clear();
        m_bits.delete();
        m_mode = 0; m_t = 0; m_anchor = 0; m_nidle = 0; m_nbad = 0;
        m_sync = 0; m_valid = 0; m_lost = 0; m_locked = 0; m_word = 8'h00;
        prev_locked = 0; last_sync = -1;
    endtask

    task automatic model_step(input bit b);
        logic [7:0] w;
        bit on_b;
        m_bits.push_back(b);
        if (m_bits.size() > 8) void'(m_bits.pop_front());
        w = 8'h00;
        foreach (m_bits[i]) w = {w[6:0], m_bits[i]};
        m_sync = 0; m_valid = 0; m_lost = 0;
        on_b = (m_mode != 0) && (m_t > m_anchor) && (((m_t - m_anchor) % 8) == 0);
        if (m_mode == 0) begin
            if (w == IDLE) begin
                m_anchor = m_t; m_nidle = 1; m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (on_b) begin
                if (w == IDLE) begin
                    m_nidle++;
                    if (m_nidle == LOCK_COUNT) begin
                        m_mode = 2; m_nbad = 0;
                        m_sync = 1; m_word = w; m_locked = 1;
                    end
                end else begin
                    m_mode = 0;
                end
            end
        end else begin
            if (on_b) begin
                m_sync = 1; m_word = w;
                if (w == IDLE) m_nbad = 0;
                else begin
                    m_valid = 1;
                    m_nbad++;
                    if (m_nbad == IDLE_TIMEOUT) begin
                        m_mode = 0; m_lost = 1; m_locked = 0;
                    end
                end
            end
        end
        m_t++;
    endtask

    task automatic step(input bit b);
        int now;
        @(negedge clk);
        din = b;
        now = m_t;
        model_step(b);
        @(posedge clk);
        #1;
        check_eq("clk_sync_tx", 32'(clk_sync_tx), 32'(m_sync));
        check_eq("cmd_valid",   32'(cmd_valid),   32'(m_valid));
        check_eq("locked",      32'(locked),      32'(m_locked));
        check_eq("lock_lost",   32'(lock_lost),   32'(m_lost));
        check_eq("cmd_word",    32'(cmd_word),    32'(m_word));
        if (clk_sync_tx) begin
            cnt_sync++;
            if (last_sync >= 0) check_eq("sync_period", 32'(now - last_sync), 32'd8);
            last_sync = lock_lost ? -1 : now;
        end
        if (cmd_valid) cnt_valid++;
        if (lock_lost) cnt_lost++;
        if (locked && !prev_locked) begin
            cnt_rise++;
            rise_t = now;
        end
        prev_locked = locked;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) step(b[i]);
    endtask

    task automatic clear_counts();
        cnt_sync = 0; cnt_valid = 0; cnt_lost = 0; cnt_rise = 0; rise_t = -1;
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_sync"},   32'(clk_sync_tx), 32'd0);
        check_eq({tag, "_valid"},  32'(cmd_valid),   32'd0);
        check_eq({tag, "_locked"}, 32'(locked),      32'd0);
        check_eq({tag, "_lost"},   32'(lock_lost),   32'd0);
        check_eq({tag, "_word"},   32'(cmd_word),    32'd0);
    endtask

    // Assert reset just after a rising edge, check outputs clear without any
    // clock edge, hold it with random din, then release before the next negedge.
    task automatic reset_mid();
        @(posedge clk);
        #3;
        n_reset = 1'b0;
        #1;
        check_zero("rst_async");
        repeat (4) begin
            @(negedge clk);
            din = 1'($urandom);
            @(posedge clk);
            #1;
            check_zero("rst_hold");
        end
        model_clear();
        n_reset = 1'b1;
    endtask

    int first_t;
    int off;
    logic [7:0] cmd;
    int n_cmd;

    initial begin
        model_clear();
        clear_counts();

        // Reset held with random serial data.
        repeat (10) begin
            @(negedge clk);
            din = 1'($urandom);
            @(posedge clk);
            #1;
            check_zero("reset");
        end
        n_reset = 1'b1;

        // Lock acquisition at a random bit offset; zero bits cannot form an IDLE.
        clear_counts();
        off = $urandom_range(0, 7);
        repeat (off) step(1'b0);
        first_t = m_t + 7;
        repeat (10) send_byte(IDLE);
        // The compare of step n observes the cycle after that step's edge, hence +1.
        check_eq("lock_latency", 32'(rise_t - first_t + 1), 32'(8 * (LOCK_COUNT - 1) + 1));
        check_eq("acq_syncs", 32'(cnt_sync), 32'(10 - LOCK_COUNT + 1));
        check_eq("acq_valids", 32'(cnt_valid), 32'd0);

        // Command pass-through between IDLE frames.
        clear_counts();
        send_byte(IDLE);
        send_byte(8'h5A);
        check_eq("pt_word", 32'(cmd_word), 32'h5A);
        check_eq("pt_valid", 32'(cmd_valid), 32'd1);
        check_eq("pt_sync", 32'(clk_sync_tx), 32'd1);
        send_byte(IDLE);
        check_eq("pt_idle_valid", 32'(cmd_valid), 32'd0);
        n_cmd = 1;
        repeat (12) begin
            cmd = 8'($urandom_range(0, 255));
            if (cmd == IDLE) cmd = 8'h5A;
            send_byte(cmd);
            send_byte(IDLE);
            n_cmd++;
        end
        check_eq("pt_valid_count", 32'(cnt_valid), 32'(n_cmd));
        check_eq("pt_locked", 32'(locked), 32'd1);

        // Loss of lock after IDLE_TIMEOUT non-IDLE frames.
        clear_counts();
        repeat (IDLE_TIMEOUT) send_byte(8'h5A);
        check_eq("lol_valids", 32'(cnt_valid), 32'(IDLE_TIMEOUT));
        check_eq("lol_lost", 32'(lock_lost), 32'd1);
        check_eq("lol_locked", 32'(locked), 32'd0);
        check_eq("lol_last_sync", 32'(clk_sync_tx), 32'd1);
        check_eq("lol_lost_count", 32'(cnt_lost), 32'd1);
        clear_counts();
        repeat (16) send_byte(8'h5A);
        check_eq("lol_no_sync", 32'(cnt_sync), 32'd0);

        // Verify abort then clean re-acquisition.
        clear_counts();
        send_byte(IDLE);
        send_byte(IDLE);
        send_byte(8'h33);
        check_eq("abort_no_lock", 32'(cnt_rise), 32'd0);
        repeat (LOCK_COUNT) send_byte(IDLE);
        check_eq("abort_relock", 32'(locked), 32'd1);
        check_eq("abort_rise", 32'(cnt_rise), 32'd1);

        // Phase slip of 3 bits: no realignment until timeout, then relock.
        clear_counts();
        repeat (4) send_byte(IDLE);
        repeat (3) step(1'b0);
        repeat (80) send_byte(IDLE);
        check_eq("slip_lost", 32'(cnt_lost), 32'd1);
        check_eq("slip_relock", 32'(cnt_rise), 32'd1);
        check_eq("slip_locked", 32'(locked), 32'd1);
        check_eq("slip_valids", 32'(cnt_valid), 32'(IDLE_TIMEOUT));

        // Reset in the middle of a frame, then re-acquire.
        step(1'b1);
        step(1'b0);
        step(1'b1);
        reset_mid();
        clear_counts();
        repeat (LOCK_COUNT + 2) send_byte(IDLE);
        check_eq("post_rst_locked", 32'(locked), 32'd1);
        check_eq("post_rst_rise", 32'(cnt_rise), 32'd1);

        // Random soak: IDLE/command mix with occasional bit slips.
        repeat (200) begin
            if ($urandom_range(0, 1) == 0) send_byte(IDLE);
            else send_byte(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 39) == 0) repeat ($urandom_range(1, 7)) step(1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
